writeback_driver: RTL and testbench

WRITEBACK_DRIVER -- requirements
Module: writeback_driver

---
 rtl/writeback_driver.sv | 106 ++++++++++
 tb/tb_writeback_driver.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_driver.sv
// Buffered register-file write driver: a small FIFO of pending writes drained
// one per cycle into a registered write port, with a forwarding lookup over in-flight writes.
module writeback_driver #(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [3:0]  in_address,
   input  logic [63:0] in_data,
   output logic [3:0]  write_port_address,
   output logic [63:0] write_data,
   output logic        is_write,
   input  logic [3:0]  query_address,
   output logic        query_hit,
   output logic [63:0] query_data,
   output logic [15:0] pending_mask,
   output logic [3:0]  buffer_count
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [3:0]       fifo_addr [DEPTH];
   logic [63:0]      fifo_data [DEPTH];
   logic [DEPTH-1:0] fifo_valid;
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [3:0]       count;
   logic             push;
   logic             pop;

   // Acceptance looks only at the registered count, so a full FIFO stalls the
   // producer for one cycle even though a pop frees a slot at the same edge.
   assign in_ready     = !rst && (count < 4'(DEPTH));
   assign push         = in_valid && in_ready;
   assign pop          = (count != 4'd0);
   assign buffer_count = count;

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_addr[wr_ptr] <= in_address;
         fifo_data[wr_ptr] <= in_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr             <= '0;
         rd_ptr             <= '0;
         count              <= '0;
         fifo_valid         <= '0;
         is_write           <= 1'b0;
         write_port_address <= '0;
         write_data         <= '0;
      end else begin
         if (pop) begin
            fifo_valid[rd_ptr] <= 1'b0;
            rd_ptr             <= rd_ptr + 1'b1;
            is_write           <= 1'b1;
            write_port_address <= fifo_addr[rd_ptr];
            write_data         <= fifo_data[rd_ptr];
         end else begin
            is_write <= 1'b0;
         end
         if (push) begin
            fifo_valid[wr_ptr] <= 1'b1;
            wr_ptr             <= wr_ptr + 1'b1;
         end
         count <= count + {3'b000, push} - {3'b000, pop};
      end
   end

   always_comb begin
      pending_mask = '0;
      if (!rst) begin
         if (is_write) pending_mask[write_port_address] = 1'b1;
         for (int i = 0; i < DEPTH; i++) begin
            if (fifo_valid[i]) pending_mask[fifo_addr[i]] = 1'b1;
         end
      end
   end

   // Walk oldest to youngest so the youngest matching entry wins; the output
   // stage is older than every FIFO entry and only seeds the result.
   logic [PW-1:0] idx;
   always_comb begin
      query_hit  = 1'b0;
      query_data = '0;
      idx        = '0;
      if (!rst) begin
         if (is_write && (write_port_address == query_address)) begin
            query_hit  = 1'b1;
            query_data = write_data;
         end
         for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr + PW'(i);
            if (fifo_valid[idx] && (fifo_addr[idx] == query_address)) begin
               query_hit  = 1'b1;
               query_data = fifo_data[idx];
            end
         end
      end
   end

endmodule

// File: tb/tb_writeback_driver.sv
// Scenario bench for writeback_driver: expected writes are queued on acceptance
// and matched in order against the write port by a monitor.
module tb_writeback_driver;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  in_address;
   logic [63:0] in_data;
   logic [3:0]  write_port_address;
   logic [63:0] write_data;
   logic        is_write;
   logic [3:0]  query_address;
   logic        query_hit;
   logic [63:0] query_data;
   logic [15:0] pending_mask;
   logic [3:0]  buffer_count;

   int checks   = 0;
   int failures = 0;
   logic [67:0] exp_q [$];

   writeback_driver #(.DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_address(in_address), .in_data(in_data),
      .write_port_address(write_port_address), .write_data(write_data),
      .is_write(is_write),
      .query_address(query_address), .query_hit(query_hit), .query_data(query_data),
      .pending_mask(pending_mask), .buffer_count(buffer_count)
   );

   always #5 clk = ~clk;

   // Every cycle with is_write=1 is one committed write; it must be the oldest expected.
   always @(negedge clk) begin
      if (!rst && is_write) begin
         logic [67:0] e;
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_write: got addr=%0d data=%h, required no write",
                     write_port_address, write_data);
         end else begin
            e = exp_q.pop_front();
            if ({write_port_address, write_data} !== e) begin
               failures++;
               $display("FAIL write_order: got addr=%0d data=%h, required addr=%0d data=%h",
                        write_port_address, write_data, e[67:64], e[63:0]);
            end
         end
      end
   end

   task automatic push_req(input logic [3:0] a, input logic [63:0] d);
      in_valid   = 1'b1;
      in_address = a;
      in_data    = d;
      if (in_ready) exp_q.push_back({a, d});
   endtask

   task automatic drain();
      in_valid = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (exp_q.size() == 0 && !is_write) break;
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; in_address = '0; in_data = '0; query_address = '0;
      #2;
      checks++;
      if ({in_ready, is_write, buffer_count, pending_mask, query_hit, query_data,
           write_port_address, write_data} !== '0) begin
         failures++;
         $display("FAIL reset_state: got rdy=%b wr=%b cnt=%0d pm=%h hit=%b qd=%h wa=%0d wd=%h, required all 0",
                  in_ready, is_write, buffer_count, pending_mask, query_hit, query_data,
                  write_port_address, write_data);
      end
      @(negedge clk);
      rst = 1'b0;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         failures++;
         $display("FAIL ready_after_reset: got %b, required 1", in_ready);
      end
   endtask

   task automatic test_single_write();
      @(negedge clk);
      query_address = 4'd3;
      push_req(4'd3, 64'hDEAD_BEEF);
      #1;
      checks++;
      if (pending_mask !== 16'h0 || query_hit !== 1'b0) begin
         failures++;
         $display("FAIL same_cycle_invisible: got pm=%h hit=%b, required pm=0 hit=0", pending_mask, query_hit);
      end
      @(negedge clk);
      in_valid = 1'b0;
      checks++;
      if (buffer_count !== 4'd1 || pending_mask !== 16'h0008 || is_write !== 1'b0 ||
          query_hit !== 1'b1 || query_data !== 64'hDEAD_BEEF) begin
         failures++;
         $display("FAIL single_buffered: got cnt=%0d pm=%h wr=%b hit=%b qd=%h, required 1 0008 0 1 deadbeef",
                  buffer_count, pending_mask, is_write, query_hit, query_data);
      end
      @(negedge clk);
      checks++;
      if (is_write !== 1'b1 || write_port_address !== 4'd3 || write_data !== 64'hDEAD_BEEF ||
          pending_mask !== 16'h0008 || buffer_count !== 4'd0) begin
         failures++;
         $display("FAIL single_out: got wr=%b wa=%0d wd=%h pm=%h cnt=%0d, required 1 3 deadbeef 0008 0",
                  is_write, write_port_address, write_data, pending_mask, buffer_count);
      end
      @(negedge clk);
      checks++;
      if (is_write !== 1'b0 || pending_mask !== 16'h0 || query_hit !== 1'b0 ||
          write_port_address !== 4'd3 || write_data !== 64'hDEAD_BEEF) begin
         failures++;
         $display("FAIL single_done: got wr=%b pm=%h hit=%b wa=%0d wd=%h, required 0 0000 0 3 deadbeef (held)",
                  is_write, pending_mask, query_hit, write_port_address, write_data);
      end
   endtask

   task automatic test_flag_register();
      @(negedge clk);
      push_req(4'd15, 64'h1);
      @(negedge clk);
      in_valid = 1'b0;
      checks++;
      if (pending_mask !== 16'h8000) begin
         failures++;
         $display("FAIL flag_pending: got %h, required 8000", pending_mask);
      end
      @(negedge clk);
      checks++;
      if (is_write !== 1'b1 || write_port_address !== 4'd15 || write_data[0] !== 1'b1 ||
          pending_mask !== 16'h8000) begin
         failures++;
         $display("FAIL flag_write: got wr=%b wa=%0d d0=%b pm=%h, required 1 15 1 8000",
                  is_write, write_port_address, write_data[0], pending_mask);
      end
      @(negedge clk);
      checks++;
      if (pending_mask !== 16'h0) begin
         failures++;
         $display("FAIL flag_cleared: got %h, required 0000", pending_mask);
      end
   endtask

   task automatic test_forwarding_order();
      @(negedge clk);
      query_address = 4'd7;
      push_req(4'd7, 64'h11);
      @(negedge clk);
      push_req(4'd7, 64'h22);
      checks++;
      if (query_hit !== 1'b1 || query_data !== 64'h11) begin
         failures++;
         $display("FAIL fwd_first: got hit=%b qd=%h, required 1 11", query_hit, query_data);
      end
      @(negedge clk);
      in_valid = 1'b0;
      checks++;
      if (query_hit !== 1'b1 || query_data !== 64'h22 || write_data !== 64'h11 || is_write !== 1'b1) begin
         failures++;
         $display("FAIL fwd_youngest: got hit=%b qd=%h wd=%h wr=%b, required 1 22 11 1",
                  query_hit, query_data, write_data, is_write);
      end
      @(negedge clk);
      checks++;
      if (write_data !== 64'h22 || query_data !== 64'h22 || query_hit !== 1'b1) begin
         failures++;
         $display("FAIL fwd_second: got wd=%h qd=%h hit=%b, required 22 22 1", write_data, query_data, query_hit);
      end
      @(negedge clk);
      checks++;
      if (query_hit !== 1'b0 || query_data !== 64'h0) begin
         failures++;
         $display("FAIL fwd_empty: got hit=%b qd=%h, required 0 0", query_hit, query_data);
      end
   endtask

   task automatic test_back_to_back_wrap();
      int bad = 0;
      @(negedge clk);
      for (int i = 0; i < 12; i++) begin
         push_req(4'(i), {$urandom, $urandom});
         @(negedge clk);
         checks++;
         if (buffer_count > 4'd1) begin
            failures++; bad++;
            $display("FAIL wrap_count: step %0d got cnt=%0d, required <=1", i, buffer_count);
         end
      end
      drain();
   endtask

   task automatic test_backpressure();
      @(negedge clk);
      for (int i = 1; i <= 5; i++) begin
         push_req(4'(i), 64'(i));
         checks++;
         if (in_ready !== (buffer_count < 4'(DEPTH))) begin
            failures++;
            $display("FAIL ready_vs_count: got rdy=%b cnt=%0d, required rdy=%b",
                     in_ready, buffer_count, (buffer_count < 4'(DEPTH)));
         end
         @(negedge clk);
      end
      drain();
   endtask

   task automatic test_reset_midop();
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         push_req(4'(8 + i), 64'hA0 + 64'(i));
         @(negedge clk);
      end
      push_req(4'd12, 64'hAB);
      @(posedge clk);
      #2;
      rst = 1'b1;
      in_valid = 1'b0;
      #1;
      exp_q.delete();
      checks++;
      if (is_write !== 1'b0 || pending_mask !== 16'h0 || buffer_count !== 4'd0 ||
          in_ready !== 1'b0 || query_hit !== 1'b0) begin
         failures++;
         $display("FAIL reset_midop: got wr=%b pm=%h cnt=%0d rdy=%b hit=%b, required all 0",
                  is_write, pending_mask, buffer_count, in_ready, query_hit);
      end
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checks++;
         if (is_write !== 1'b0 || pending_mask !== 16'h0) begin
            failures++;
            $display("FAIL post_reset_idle: got wr=%b pm=%h, required 0 0000", is_write, pending_mask);
         end
      end
      push_req(4'd0, 64'h5A5A);
      @(negedge clk);
      in_valid = 1'b0;
      checks++;
      if (pending_mask !== 16'h0001) begin
         failures++;
         $display("FAIL post_reset_push: got pm=%h, required 0001", pending_mask);
      end
      drain();
   endtask

   initial begin
      test_reset();
      test_single_write();
      test_flag_register();
      test_forwarding_order();
      test_back_to_back_wrap();
      test_backpressure();
      test_reset_midop();
      drain();
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL missing_writes: got %0d outstanding, required 0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
